// File: rtl/temporal_pkg.sv
// temporal_pkg: shared channel state encoding, the "no fire" timestamp
// constant and the event-polarity helper for the race-logic GE array.
package temporal_pkg;

  typedef enum logic [1:0] {
    WAIT    = 2'd0,
    B_SEEN  = 2'd1,
    FIRED   = 2'd2,
    BLOCKED = 2'd3
  } tge_state_t;

  // All-ones timestamp meaning "a never fired"; truncate to TW bits at use.
  localparam logic [31:0] TGE_NO_FIRE = '1;

  // Map a raw spike line to its active-high level for the selected edge
  // polarity (falling-edge coding is handled by inverting the line).
  function automatic logic tge_edge_level(input logic x, input logic falling);
    return x ^ falling;
  endfunction

endpackage

// File: rtl/tge_channel.sv
// tge_channel: one race-logic a>=b comparator. It holds the a/b edge
// detectors, the WAIT/B_SEEN/FIRED/BLOCKED state machine and, when
// TGE_TIMESTAMP_EN is defined, the fire-time capture register.
module tge_channel
  import temporal_pkg::*;
#(
  parameter int TW      = 6,
  parameter int FALLING = 0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_grst,
  input  logic          i_active,
  input  logic          i_timeout,
  input  logic          i_a,
  input  logic          i_b,
`ifdef TGE_TIMESTAMP_EN
  input  logic [TW-1:0] i_t,
  output logic [TW-1:0] o_q_time,
`endif
  output logic          o_q,
  output logic          o_resolved_nxt
);

  localparam logic L_FALLING = (FALLING != 0);

  tge_state_t r_state;
  tge_state_t w_state_nxt;
  logic       r_prev_a;
  logic       r_prev_b;
  logic       w_a_lvl;
  logic       w_b_lvl;
  logic       w_ea;
  logic       w_eb;

  assign w_a_lvl = tge_edge_level(i_a, L_FALLING);
  assign w_b_lvl = tge_edge_level(i_b, L_FALLING);
  assign w_ea    = w_a_lvl & ~r_prev_a;
  assign w_eb    = w_b_lvl & ~r_prev_b;

  // Next-state logic: grst restarts the race, otherwise resolve on the
  // first a-event. Timeout wins over an event sampled in the T_MAX cycle.
  always_comb begin
    // NOTE: the default is assigned first so every path drives w_state_nxt and no latch is inferred.
    w_state_nxt = r_state;
    if (i_grst) begin
      w_state_nxt = WAIT;
    end else if (i_active) begin
      case (r_state)
        WAIT: begin
          if (i_timeout)  w_state_nxt = BLOCKED;
          else if (w_ea)  w_state_nxt = w_eb ? FIRED : BLOCKED;
          else if (w_eb)  w_state_nxt = B_SEEN;
        end
        B_SEEN: begin
          if (i_timeout)  w_state_nxt = BLOCKED;
          else if (w_ea)  w_state_nxt = FIRED;
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // State and edge registers. The previous-level registers always track the
  // current level, so in the grst cycle they take the held lines as baseline.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!i_rst_n) begin
      r_state  <= WAIT;
      r_prev_a <= 1'b0;
      r_prev_b <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_prev_a <= w_a_lvl;
      r_prev_b <= w_b_lvl;
    end
  end

  assign o_q            = (r_state == FIRED);
  assign o_resolved_nxt = (w_state_nxt == FIRED) || (w_state_nxt == BLOCKED);

`ifdef TGE_TIMESTAMP_EN
  logic [TW-1:0] r_q_time;

  // Capture the window time of the sample that moves the channel into FIRED.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_grst) begin
      r_q_time <= TW'(TGE_NO_FIRE);
    end else if ((r_state != FIRED) && (w_state_nxt == FIRED)) begin
      r_q_time <= i_t;
    end
  end

  assign o_q_time = r_q_time;
`endif

endmodule

// File: rtl/temporal_ge_array.sv
// temporal_ge_array: N independent race-logic a>=b comparators sharing one
// gamma-window timer. The top owns the timer, the timeout broadcast and the
// done reduction. Optional macro TGE_TIMESTAMP_EN adds the q_time output.
module temporal_ge_array
  import temporal_pkg::*;
#(
  parameter int N       = 8,
  parameter int TW      = 6,
  parameter int T_MAX   = 63,
  parameter int FALLING = 0
) (
  input  logic            aclk,
  input  logic            rst,
  input  logic            grst,
  input  logic [N-1:0]    a,
  input  logic [N-1:0]    b,
  output logic [N-1:0]    q,
  output logic [TW-1:0]   t,
`ifdef TGE_TIMESTAMP_EN
  output logic [N*TW-1:0] q_time,
`endif
  output logic            done
);

  localparam logic [TW-1:0] L_T_MAX = TW'(T_MAX);

  logic          r_active;
  logic [TW-1:0] r_t;
  logic [TW-1:0] w_t_nxt;
  logic          r_done;
  logic          w_timeout;
  logic [N-1:0]  w_resolved_nxt;

  // Window timer: cleared by grst, counts only once a window is open and
  // saturates at the last cycle of the window.
  always_comb begin
    w_t_nxt = r_t;
    if (grst) begin
      w_t_nxt = '0;
    end else if (r_active && (r_t != L_T_MAX)) begin
      w_t_nxt = r_t + TW'(1);
    end
  end

  assign w_timeout = r_active && (r_t == L_T_MAX);

  // Window-open flag, timer and done; done is loaded from next-state values
  // so it appears together with the state or time that resolves the window.
  always_ff @(posedge aclk) begin
    if (!rst) begin
      r_active <= 1'b0;
      r_t      <= '0;
      r_done   <= 1'b0;
    end else begin
      if (grst) r_active <= 1'b1;
      r_t    <= w_t_nxt;
      r_done <= !grst && r_active && ((&w_resolved_nxt) || (w_t_nxt == L_T_MAX));
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_ch
    tge_channel #(
      .TW      (TW),
      .FALLING (FALLING)
    ) u_ch (
      .i_clk          (aclk),
      .i_rst_n        (rst),
      .i_grst         (grst),
      .i_active       (r_active),
      .i_timeout      (w_timeout),
      .i_a            (a[gi]),
      .i_b            (b[gi]),
`ifdef TGE_TIMESTAMP_EN
      .i_t            (r_t),
      .o_q_time       (q_time[gi*TW +: TW]),
`endif
      .o_q            (q[gi]),
      .o_resolved_nxt (w_resolved_nxt[gi])
    );
  end

  assign t    = r_t;
  assign done = r_done;

endmodule
